// File: rtl/popcount_stream.sv
// Streaming population counter: per-word bit counts or saturating per-frame totals.
// Latency: 2 cycles from accepted word (or last word of a frame) to O_valid.
// Backpressure: pipeline freezes when O_valid && !O_ready; I_ready drops in the same cycle.
//
// Ports:
//   CLK, RESETN          clock, synchronous active-low reset
//   I_valid/I_ready      input handshake; I_data word, I_last frame end, I_mode 0=per-word 1=accumulate
//   O_valid/O_ready      output handshake; O_count zero-extended result, O_overflow frame saturated
module popcount_stream #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 I_valid,
    output logic                 I_ready,
    input  logic [WIDTH-1:0]     I_data,
    input  logic                 I_last,
    input  logic                 I_mode,
    output logic                 O_valid,
    input  logic                 O_ready,
    output logic [ACC_WIDTH-1:0] O_count,
    output logic                 O_overflow
);

    localparam int CW     = $clog2(WIDTH + 1);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NP     = 1 << LEVELS;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] cnt;
        logic          last;
        logic          mode;
    } s1_t;

    s1_t                  s1;
    logic                 out_vld;
    logic [ACC_WIDTH-1:0] out_cnt;
    logic                 out_ovf;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_ovf;

    logic                 en;
    logic                 in_acc;
    logic [CW-1:0]        word_cnt;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_next;
    logic [ACC_WIDTH-1:0] sat_sum;

    // Whole pipeline moves only when the output register is empty or being drained.
    assign en      = !out_vld || O_ready;
    assign I_ready = en && RESETN;
    assign in_acc  = I_valid && I_ready;

    // Balanced adder tree over the word, padded with zeros to a power of two.
    // Every node is CW bits wide: no partial sum can exceed WIDTH.
    genvar l, i;
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [CW-1:0] node [NP >> l];
        if (l == 0) begin : g_leaf
            for (i = 0; i < NP; i++) begin : g_in
                if (i < WIDTH) begin : g_bit
                    assign node[i] = CW'(I_data[i]);
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end
        end else begin : g_add
            for (i = 0; i < (NP >> l); i++) begin : g_sum
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign word_cnt = g_lvl[LEVELS].node[0];

    // One extra bit catches the carry out; once a frame has saturated it stays saturated.
    assign sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(s1.cnt);
    assign ovf_next = acc_ovf || sum[ACC_WIDTH];
    assign sat_sum  = ovf_next ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1      <= '0;
            out_vld <= 1'b0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (en) begin
            s1.vld <= in_acc;
            if (in_acc) begin
                s1.cnt  <= word_cnt;
                s1.last <= I_last;
                s1.mode <= I_mode;
            end

            if (!s1.vld) begin
                out_vld <= 1'b0;
            end else if (!s1.mode) begin
                // Per-word result passes straight through; a frame in progress is left alone.
                out_cnt <= ACC_WIDTH'(s1.cnt);
                out_ovf <= 1'b0;
                out_vld <= 1'b1;
            end else if (!s1.last) begin
                acc     <= sat_sum;
                acc_ovf <= ovf_next;
                out_vld <= 1'b0;
            end else begin
                out_cnt <= sat_sum;
                out_ovf <= ovf_next;
                out_vld <= 1'b1;
                acc     <= '0;
                acc_ovf <= 1'b0;
            end
        end
    end

    assign O_valid    = out_vld;
    assign O_count    = out_cnt;
    assign O_overflow = out_ovf;

endmodule
